axil_mem_slave: RTL and testbench

AXIL_MEM_SLAVE -- requirements
Module: axil_mem_slave

---
 rtl/axil_pkg.sv | 23 ++
 rtl/hex7seg_dec.sv | 36 +++
 rtl/axil_mem_slave.sv | 217 +++++++++++++++++++++
 tb/tb_axil_mem_slave.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite register-file slave:
//   - response codes (OKAY / SLVERR)
//   - state encodings of the independent write and read FSMs
// Optional feature macro used by the slave: AXIL_MEM_SEG_EN
// ---------------------------------------------------------------------------
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage : axil_pkg

// File: rtl/hex7seg_dec.sv
// ---------------------------------------------------------------------------
// hex7seg_dec
// Combinational hex digit to seven-segment decoder.
// Ports:
//   nibble  in  4  hex digit 0..F
//   seg     out 8  segment pattern {dp,g,f,e,d,c,b,a}, active-high, dp=0
// ---------------------------------------------------------------------------
module hex7seg_dec (
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'h00;
        case (nibble)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            4'hF: seg = 8'h71;
            default: seg = 8'h00;
        endcase
    end

endmodule : hex7seg_dec

// File: rtl/axil_mem_slave.sv
// ---------------------------------------------------------------------------
// axil_mem_slave
// AXI4-Lite slave backed by a DEPTH x DATA_W register file. Write and read
// channels are served by two independent two-state FSMs. Addresses at or
// above DEPTH are not stored/read and answer SLVERR (read data 0).
//
// Parameters: ADDR_W (address bits), DATA_W (4..32), DEPTH (<= 2**ADDR_W)
// Ports:
//   clk, reset (async, active-low)
//   AW: ms_awvalid / sm_awready, SWM_awaddr
//   W : ms_wvalid  / sm_wready,  SWM_wdata
//   B : sm_bvalid  / ms_bready,  sm_bresp
//   AR: ms_arvalid / sm_arready, SWM_araddr
//   R : sm_rvalid  / ms_rready,  sm_rdata, sm_rresp
//   disp_hex_r : seven-segment {dp,g..a} of the low nibble of the last OKAY
//                read when AXIL_MEM_SEG_EN is defined, else constant 0.
// ---------------------------------------------------------------------------
module axil_mem_slave
    import axil_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ms_awvalid,
    output logic              sm_awready,
    input  logic [ADDR_W-1:0] SWM_awaddr,
    input  logic              ms_wvalid,
    output logic              sm_wready,
    input  logic [DATA_W-1:0] SWM_wdata,
    output logic              sm_bvalid,
    input  logic              ms_bready,
    output logic [1:0]        sm_bresp,
    input  logic              ms_arvalid,
    output logic              sm_arready,
    input  logic [ADDR_W-1:0] SWM_araddr,
    output logic              sm_rvalid,
    input  logic              ms_rready,
    output logic [DATA_W-1:0] sm_rdata,
    output logic [1:0]        sm_rresp,
    output logic [7:0]        disp_hex_r
);

    // DEPTH <= 2**ADDR_W, so it always fits in ADDR_W+1 bits.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    logic [DATA_W-1:0] mem_reg [DEPTH];

    // Ready outputs stay low while in reset and rise on the first edge after.
    logic started_reg;

    w_state_t          w_state_reg, w_state_next;
    logic              aw_held_reg, aw_held_next;
    logic              w_held_reg,  w_held_next;
    logic [ADDR_W-1:0] awaddr_reg,  awaddr_next;
    logic [DATA_W-1:0] wdata_reg,   wdata_next;
    logic [1:0]        bresp_reg,   bresp_next;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    r_state_t          r_state_reg, r_state_next;
    logic [DATA_W-1:0] rdata_reg,   rdata_next;
    logic [1:0]        rresp_reg,   rresp_next;
    logic [DATA_W-1:0] rd_word;

    logic aw_hs, w_hs, ar_hs;

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started_reg <= 1'b0;
            w_state_reg <= W_IDLE;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            bresp_reg   <= RESP_OKAY;
            r_state_reg <= R_IDLE;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            started_reg <= 1'b1;
            w_state_reg <= w_state_next;
            aw_held_reg <= aw_held_next;
            w_held_reg  <= w_held_next;
            awaddr_reg  <= awaddr_next;
            wdata_reg   <= wdata_next;
            bresp_reg   <= bresp_next;
            r_state_reg <= r_state_next;
            rdata_reg   <= rdata_next;
            rresp_reg   <= rresp_next;
            // Non-blocking update: a read on the same edge sees the old word.
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && wr_addr == ADDR_W'(i)) begin
                    mem_reg[i] <= wr_data;
                end
            end
        end
    end

    // ---------------- write FSM next state ----------------
    always_comb begin
        w_state_next = w_state_reg;
        aw_held_next = aw_held_reg;
        w_held_next  = w_held_reg;
        awaddr_next  = awaddr_reg;
        wdata_next   = wdata_reg;
        bresp_next   = bresp_reg;
        wr_en        = 1'b0;
        // Use the captured beat if held, otherwise the one handshaking now.
        wr_addr      = aw_held_reg ? awaddr_reg : SWM_awaddr;
        wr_data      = w_held_reg  ? wdata_reg  : SWM_wdata;
        case (w_state_reg)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_next = 1'b1;
                    awaddr_next  = SWM_awaddr;
                end
                if (w_hs) begin
                    w_held_next = 1'b1;
                    wdata_next  = SWM_wdata;
                end
                if ((aw_held_reg || aw_hs) && (w_held_reg || w_hs)) begin
                    w_state_next = W_RESP;
                    aw_held_next = 1'b0;
                    w_held_next  = 1'b0;
                    wr_en        = addr_ok(wr_addr);
                    bresp_next   = addr_ok(wr_addr) ? RESP_OKAY : RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (ms_bready) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // ---------------- read FSM next state ----------------
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (SWM_araddr == ADDR_W'(i)) begin
                rd_word = mem_reg[i];
            end
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        rdata_next   = rdata_reg;
        rresp_next   = rresp_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_next = R_DATA;
                    rdata_next   = addr_ok(SWM_araddr) ? rd_word : '0;
                    rresp_next   = addr_ok(SWM_araddr) ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (ms_rready) begin
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // ---------------- outputs (registers only, no ready->valid path) ----------------
    always_comb begin
        sm_awready = started_reg && (w_state_reg == W_IDLE) && !aw_held_reg;
        sm_wready  = started_reg && (w_state_reg == W_IDLE) && !w_held_reg;
        sm_bvalid  = (w_state_reg == W_RESP);
        sm_bresp   = bresp_reg;
        sm_arready = started_reg && (r_state_reg == R_IDLE);
        sm_rvalid  = (r_state_reg == R_DATA);
        sm_rdata   = rdata_reg;
        sm_rresp   = rresp_reg;
    end

    assign aw_hs = ms_awvalid && sm_awready;
    assign w_hs  = ms_wvalid  && sm_wready;
    assign ar_hs = ms_arvalid && sm_arready;

`ifdef AXIL_MEM_SEG_EN
    // Nibble follows the R channel but only for OKAY reads.
    logic [3:0] seg_nibble_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_nibble_reg <= 4'h0;
        end else if (ar_hs && addr_ok(SWM_araddr)) begin
            seg_nibble_reg <= rd_word[3:0];
        end
    end

    hex7seg_dec u_hex7seg_dec (
        .nibble (seg_nibble_reg),
        .seg    (disp_hex_r)
    );
`else
    assign disp_hex_r = 8'h00;
`endif

endmodule : axil_mem_slave

// File: tb/tb_axil_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_axil_mem_slave
// Directed bench for axil_mem_slave (DEPTH=12 so out-of-range is reachable).
// Display expectations follow AXIL_MEM_SEG_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_axil_mem_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       ms_awvalid, sm_awready;
    logic [3:0] SWM_awaddr;
    logic       ms_wvalid, sm_wready;
    logic [7:0] SWM_wdata;
    logic       sm_bvalid, ms_bready;
    logic [1:0] sm_bresp;
    logic       ms_arvalid, sm_arready;
    logic [3:0] SWM_araddr;
    logic       sm_rvalid, ms_rready;
    logic [7:0] sm_rdata;
    logic [1:0] sm_rresp;
    logic [7:0] disp_hex_r;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    axil_mem_slave #(.ADDR_W(4), .DATA_W(8), .DEPTH(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .ms_awvalid (ms_awvalid),
        .sm_awready (sm_awready),
        .SWM_awaddr (SWM_awaddr),
        .ms_wvalid  (ms_wvalid),
        .sm_wready  (sm_wready),
        .SWM_wdata  (SWM_wdata),
        .sm_bvalid  (sm_bvalid),
        .ms_bready  (ms_bready),
        .sm_bresp   (sm_bresp),
        .ms_arvalid (ms_arvalid),
        .sm_arready (sm_arready),
        .SWM_araddr (SWM_araddr),
        .sm_rvalid  (sm_rvalid),
        .ms_rready  (ms_rready),
        .sm_rdata   (sm_rdata),
        .sm_rresp   (sm_rresp),
        .disp_hex_r (disp_hex_r)
    );

    function automatic logic [7:0] exp_disp(input logic [7:0] pattern);
`ifdef AXIL_MEM_SEG_EN
        return pattern;
`else
        return 8'h00;
`endif
    endfunction

    // Full write with bready raised once bvalid is seen. lat = edges between
    // the completing handshake edge and bvalid being observed (0 = next cycle).
    task automatic wr(input logic [3:0] a, input logic [7:0] d,
                      output logic [1:0] resp, output int lat);
        int   n;
        logic aw_done, w_done;
        SWM_awaddr = a; SWM_wdata = d;
        ms_awvalid = 1'b1; ms_wvalid = 1'b1; ms_bready = 1'b0;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            if (sm_awready && ms_awvalid) aw_done = 1'b1;
            if (sm_wready && ms_wvalid)   w_done  = 1'b1;
            @(posedge clk); #1; n++;
            if (aw_done) ms_awvalid = 1'b0;
            if (w_done)  ms_wvalid  = 1'b0;
        end
        ms_awvalid = 1'b0; ms_wvalid = 1'b0;
        lat = (n >= 20) ? 99 : 0;
        while (!sm_bvalid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        resp = sm_bresp;
        ms_bready = 1'b1;
        @(posedge clk); #1;
        ms_bready = 1'b0;
        $display("wr addr=%0d data=%h resp=%b lat=%0d", a, d, resp, lat);
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] data,
                      output logic [1:0] resp, output int lat);
        int n;
        SWM_araddr = a; ms_arvalid = 1'b1; n = 0;
        while (!sm_arready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        ms_arvalid = 1'b0;
        lat = (n >= 20) ? 99 : 0;
        while (!sm_rvalid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        data = sm_rdata; resp = sm_rresp;
        ms_rready = 1'b1;
        @(posedge clk); #1;
        ms_rready = 1'b0;
        $display("rd addr=%0d data=%h resp=%b lat=%0d disp=%h", a, data, resp, lat, disp_hex_r);
    endtask

    task automatic test_reset();
        #2;
        total_cnt++; if (sm_awready !== 1'b0) $display("FAIL reset_awready got=%b want=0", sm_awready); else pass_cnt++;
        total_cnt++; if (sm_arready !== 1'b0) $display("FAIL reset_arready got=%b want=0", sm_arready); else pass_cnt++;
        total_cnt++; if (sm_bvalid !== 1'b0 || sm_rvalid !== 1'b0) $display("FAIL reset_valids got=%b%b want=00", sm_bvalid, sm_rvalid); else pass_cnt++;
        total_cnt++; if (sm_rdata !== 8'h00 || sm_rresp !== 2'b00 || sm_bresp !== 2'b00) $display("FAIL reset_data got=%h/%b/%b want=00/00/00", sm_rdata, sm_rresp, sm_bresp); else pass_cnt++;
        total_cnt++; if (disp_hex_r !== exp_disp(8'h3F)) $display("FAIL reset_disp got=%h want=%h", disp_hex_r, exp_disp(8'h3F)); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (sm_wready !== 1'b0) $display("FAIL reset_hold_wready got=%b want=0", sm_wready); else pass_cnt++;
        @(negedge clk); reset = 1'b1; #1;
        total_cnt++; if (sm_awready !== 1'b0) $display("FAIL release_pre_edge got=%b want=0", sm_awready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if ({sm_awready, sm_wready, sm_arready} !== 3'b111) $display("FAIL release_readies got=%b want=111", {sm_awready, sm_wready, sm_arready}); else pass_cnt++;
    endtask

    task automatic test_write();
        logic [1:0] resp; logic [7:0] data; int lat;
        wr(4'd3, 8'h4A, resp, lat);
        total_cnt++; if (lat !== 0) $display("FAIL write_b_latency got=%0d want=0", lat); else pass_cnt++;
        total_cnt++; if (resp !== 2'b00) $display("FAIL write_bresp got=%b want=00", resp); else pass_cnt++;
        total_cnt++; if (sm_bvalid !== 1'b0 || sm_awready !== 1'b1) $display("FAIL write_back_idle got=%b%b want=01", sm_bvalid, sm_awready); else pass_cnt++;
        rd(4'd3, data, resp, lat);
        total_cnt++; if (data !== 8'h4A) $display("FAIL read3_data got=%h want=4a", data); else pass_cnt++;
        total_cnt++; if (resp !== 2'b00) $display("FAIL read3_resp got=%b want=00", resp); else pass_cnt++;
        total_cnt++; if (lat !== 0) $display("FAIL read3_latency got=%0d want=0", lat); else pass_cnt++;
        total_cnt++; if (disp_hex_r !== exp_disp(8'h77)) $display("FAIL read3_disp got=%h want=%h", disp_hex_r, exp_disp(8'h77)); else pass_cnt++;
    endtask

    task automatic test_w_first();
        logic [1:0] resp; logic [7:0] data; int lat;
        SWM_awaddr = 4'd5; SWM_wdata = 8'h11; ms_wvalid = 1'b1; ms_bready = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (sm_wready !== 1'b0 || sm_bvalid !== 1'b0) $display("FAIL wfirst_w_captured got=%b%b want=00", sm_wready, sm_bvalid); else pass_cnt++;
        ms_wvalid = 1'b0; SWM_wdata = 8'hFF;
        @(posedge clk); #1;
        total_cnt++; if (sm_bvalid !== 1'b0) $display("FAIL wfirst_no_early_b got=%b want=0", sm_bvalid); else pass_cnt++;
        ms_awvalid = 1'b1;
        @(posedge clk); #1;
        ms_awvalid = 1'b0;
        total_cnt++; if (sm_bvalid !== 1'b1 || sm_bresp !== 2'b00) $display("FAIL wfirst_b got=%b/%b want=1/00", sm_bvalid, sm_bresp); else pass_cnt++;
        total_cnt++; if (sm_awready !== 1'b0 || sm_wready !== 1'b0) $display("FAIL wfirst_ready_in_resp got=%b%b want=00", sm_awready, sm_wready); else pass_cnt++;
        ms_bready = 1'b1;
        @(posedge clk); #1;
        ms_bready = 1'b0;
        total_cnt++; if ({sm_bvalid, sm_awready, sm_wready} !== 3'b011) $display("FAIL wfirst_return got=%b want=011", {sm_bvalid, sm_awready, sm_wready}); else pass_cnt++;
        rd(4'd5, data, resp, lat);
        total_cnt++; if (data !== 8'h11 || resp !== 2'b00) $display("FAIL read5 got=%h/%b want=11/00", data, resp); else pass_cnt++;
        total_cnt++; if (disp_hex_r !== exp_disp(8'h06)) $display("FAIL read5_disp got=%h want=%h", disp_hex_r, exp_disp(8'h06)); else pass_cnt++;
    endtask

    task automatic test_slverr();
        logic [1:0] resp; logic [7:0] data; int lat;
        wr(4'd14, 8'hEE, resp, lat);
        total_cnt++; if (resp !== 2'b10) $display("FAIL oor_bresp got=%b want=10", resp); else pass_cnt++;
        rd(4'd14, data, resp, lat);
        total_cnt++; if (data !== 8'h00 || resp !== 2'b10) $display("FAIL oor_read got=%h/%b want=00/10", data, resp); else pass_cnt++;
        total_cnt++; if (disp_hex_r !== exp_disp(8'h06)) $display("FAIL oor_disp_kept got=%h want=%h", disp_hex_r, exp_disp(8'h06)); else pass_cnt++;
        rd(4'd3, data, resp, lat);
        total_cnt++; if (data !== 8'h4A) $display("FAIL oor_no_side_write got=%h want=4a", data); else pass_cnt++;
    endtask

    task automatic test_read_stall();
        SWM_araddr = 4'd5; ms_arvalid = 1'b1; ms_rready = 1'b0;
        @(posedge clk); #1;
        ms_arvalid = 1'b0; SWM_araddr = 4'd3;
        for (int i = 0; i < 5; i++) begin
            total_cnt++; if (sm_rvalid !== 1'b1 || sm_rdata !== 8'h11 || sm_arready !== 1'b0)
                $display("FAIL stall_cycle%0d got=%b/%h/%b want=1/11/0", i, sm_rvalid, sm_rdata, sm_arready);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        ms_rready = 1'b1;
        @(posedge clk); #1;
        ms_rready = 1'b0;
        total_cnt++; if (sm_rvalid !== 1'b0 || sm_arready !== 1'b1) $display("FAIL stall_release got=%b%b want=01", sm_rvalid, sm_arready); else pass_cnt++;
    endtask

    task automatic test_same_edge();
        logic [1:0] resp; logic [7:0] data; int lat;
        wr(4'd2, 8'h01, resp, lat);
        SWM_awaddr = 4'd2; SWM_wdata = 8'h02; SWM_araddr = 4'd2;
        ms_awvalid = 1'b1; ms_wvalid = 1'b1; ms_arvalid = 1'b1;
        @(posedge clk); #1;
        ms_awvalid = 1'b0; ms_wvalid = 1'b0; ms_arvalid = 1'b0;
        total_cnt++; if (sm_rvalid !== 1'b1 || sm_rdata !== 8'h01) $display("FAIL same_edge_old got=%b/%h want=1/01", sm_rvalid, sm_rdata); else pass_cnt++;
        total_cnt++; if (sm_bvalid !== 1'b1 || sm_bresp !== 2'b00) $display("FAIL same_edge_b got=%b/%b want=1/00", sm_bvalid, sm_bresp); else pass_cnt++;
        ms_rready = 1'b1; ms_bready = 1'b1;
        @(posedge clk); #1;
        ms_rready = 1'b0; ms_bready = 1'b0;
        rd(4'd2, data, resp, lat);
        total_cnt++; if (data !== 8'h02) $display("FAIL same_edge_new got=%h want=02", data); else pass_cnt++;
        total_cnt++; if (disp_hex_r !== exp_disp(8'h5B)) $display("FAIL read2_disp got=%h want=%h", disp_hex_r, exp_disp(8'h5B)); else pass_cnt++;
    endtask

    task automatic test_reset_in_resp();
        logic [1:0] resp; logic [7:0] data; int lat;
        SWM_awaddr = 4'd7; SWM_wdata = 8'h33; ms_awvalid = 1'b1; ms_wvalid = 1'b1; ms_bready = 1'b0;
        @(posedge clk); #1;
        ms_awvalid = 1'b0; ms_wvalid = 1'b0;
        total_cnt++; if (sm_bvalid !== 1'b1) $display("FAIL rst_pre_bvalid got=%b want=1", sm_bvalid); else pass_cnt++;
        #2; reset = 1'b0; #1;
        total_cnt++; if (sm_bvalid !== 1'b0 || sm_awready !== 1'b0 || sm_arready !== 1'b0) $display("FAIL rst_async got=%b%b%b want=000", sm_bvalid, sm_awready, sm_arready); else pass_cnt++;
        total_cnt++; if (sm_rdata !== 8'h00 || disp_hex_r !== exp_disp(8'h3F)) $display("FAIL rst_async_data got=%h/%h want=00/%h", sm_rdata, disp_hex_r, exp_disp(8'h3F)); else pass_cnt++;
        @(negedge clk); reset = 1'b1; #1;
        total_cnt++; if (sm_wready !== 1'b0) $display("FAIL rst2_pre_edge got=%b want=0", sm_wready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if ({sm_awready, sm_wready, sm_bvalid} !== 3'b110) $display("FAIL rst2_release got=%b want=110", {sm_awready, sm_wready, sm_bvalid}); else pass_cnt++;
        rd(4'd7, data, resp, lat);
        total_cnt++; if (data !== 8'h00 || resp !== 2'b00) $display("FAIL rst_cleared7 got=%h/%b want=00/00", data, resp); else pass_cnt++;
        rd(4'd3, data, resp, lat);
        total_cnt++; if (data !== 8'h00) $display("FAIL rst_cleared3 got=%h want=00", data); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b0;
        ms_awvalid = 1'b0; ms_wvalid = 1'b0; ms_bready = 1'b0;
        ms_arvalid = 1'b0; ms_rready = 1'b0;
        SWM_awaddr = '0; SWM_wdata = '0; SWM_araddr = '0;
        test_reset();
        test_write();
        test_w_first();
        test_slverr();
        test_read_stall();
        test_same_edge();
        test_reset_in_resp();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_axil_mem_slave
